// File: rtl/vga_pkg.sv
// Shared VGA timing constants: standard mode timings and sync polarity encodings.
// Imported by the timing generator and its delay line.
package vga_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600 @ 60 Hz, 40 MHz pixel clock
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BP     = 23;

  localparam bit VGA_POL_LOW  = 1'b0;
  localparam bit VGA_POL_HIGH = 1'b1;

  function automatic int vga_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ce-qualified shift register used to realign sync/enable with downstream read latency.
// DEPTH=0 passes din straight through with no storage.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_25m,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk_25m, rst_n, ce};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (ce) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel coordinates, sync, data-enable,
// line/frame strobes and a wrapping frame counter, all advancing on ce.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = VGA_POL_LOW,
  parameter bit VS_POL   = VGA_POL_LOW,
  parameter int CNT_W    = 10,
  parameter int FRAME_W  = 8,
  parameter int SYNC_DLY = 0
) (
  input  logic               clk_25m,
  input  logic               rst_n,
  input  logic               ce,
  output logic               hsync,
  output logic               vsync,
  output logic               valid,
  output logic [CNT_W-1:0]   pixel_x,
  output logic [CNT_W-1:0]   pixel_y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
      $error("vga_timing_gen: sync widths must be at least 1");
    end
    if (SYNC_DLY < 0 || SYNC_DLY > 7) begin : g_bad_dly
      $error("vga_timing_gen: SYNC_DLY must be in 0..7");
    end
    if ((2 ** CNT_W) < vga_max(H_TOTAL, V_TOTAL)) begin : g_bad_cnt_w
      $error("vga_timing_gen: CNT_W too narrow for the frame totals");
    end
  endgenerate

  logic [CNT_W-1:0] x_nxt, y_nxt;
  logic             hs_act_nxt, vs_act_nxt, de_nxt, ls_nxt, fs_nxt;
  logic             hs_q, vs_q, de_q;
  logic [2:0]       dly_out;

  // Decode from the next counter value so registered flags line up with pixel_x/y.
  always_comb begin
    x_nxt = (pixel_x == X_LAST) ? '0 : pixel_x + CNT_W'(1);
    y_nxt = pixel_y;
    if (pixel_x == X_LAST) y_nxt = (pixel_y == Y_LAST) ? '0 : pixel_y + CNT_W'(1);
    hs_act_nxt = (x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST);
    vs_act_nxt = (y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST);
    de_nxt     = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
    ls_nxt     = (x_nxt == '0);
    fs_nxt     = (x_nxt == '0) && (y_nxt == '0);
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x     <= X_LAST;
      pixel_y     <= Y_LAST;
      frame_cnt   <= '1;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      de_q        <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      pixel_x     <= x_nxt;
      pixel_y     <= y_nxt;
      hs_q        <= hs_act_nxt ? HS_POL : ~HS_POL;
      vs_q        <= vs_act_nxt ? VS_POL : ~VS_POL;
      de_q        <= de_nxt;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
      if (fs_nxt) frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (SYNC_DLY),
    .RST_VAL({~HS_POL, ~VS_POL, 1'b0})
  ) u_sync_dly (
    .clk_25m(clk_25m),
    .rst_n  (rst_n),
    .ce     (ce),
    .din    ({hs_q, vs_q, de_q}),
    .dout   (dly_out)
  );

  assign hsync = dly_out[2];
  assign vsync = dly_out[1];
  assign valid = dly_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four parameterisations checked every clock against a
// position-arithmetic reference model, plus directed period/latency/reset checks.
module tb_vga_timing_gen;

  typedef struct packed {
    int h_act; int h_fp; int h_sync; int h_bp;
    int v_act; int v_fp; int v_sync; int v_bp;
    bit hs_pol; bit vs_pol; int dly; int fw;
  } tparams_t;

  typedef struct packed {
    logic hs; logic vs; logic de; logic ls; logic fs;
    logic [15:0] x; logic [15:0] y; logic [15:0] fc;
  } exp_t;

  localparam tparams_t P_A = '{h_act:640, h_fp:16, h_sync:96, h_bp:48, v_act:480, v_fp:10,
                               v_sync:2, v_bp:33, hs_pol:1'b0, vs_pol:1'b0, dly:0, fw:8};
  localparam tparams_t P_B = '{h_act:640, h_fp:16, h_sync:96, h_bp:48, v_act:480, v_fp:10,
                               v_sync:2, v_bp:33, hs_pol:1'b0, vs_pol:1'b0, dly:2, fw:8};
  localparam tparams_t P_C = '{h_act:800, h_fp:40, h_sync:128, h_bp:88, v_act:600, v_fp:1,
                               v_sync:4, v_bp:23, hs_pol:1'b1, vs_pol:1'b1, dly:0, fw:8};
  localparam tparams_t P_D = '{h_act:6, h_fp:1, h_sync:2, h_bp:1, v_act:4, v_fp:1,
                               v_sync:1, v_bp:1, hs_pol:1'b1, vs_pol:1'b0, dly:3, fw:8};

  logic clk_25m = 1'b0;
  logic rst_n   = 1'b1;
  logic ce_a = 1'b0, ce_b = 1'b0, ce_c = 1'b0, ce_d = 1'b0;

  logic a_hs, a_vs, a_de, a_ls, a_fs; logic [9:0]  a_x, a_y; logic [7:0] a_fc;
  logic b_hs, b_vs, b_de, b_ls, b_fs; logic [9:0]  b_x, b_y; logic [7:0] b_fc;
  logic c_hs, c_vs, c_de, c_ls, c_fs; logic [10:0] c_x, c_y; logic [7:0] c_fc;
  logic d_hs, d_vs, d_de, d_ls, d_fs; logic [3:0]  d_x, d_y; logic [7:0] d_fc;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int k_a = 0, k_b = 0, k_c = 0, k_d = 0;
  int tick_n = 0;

  always #5 clk_25m = ~clk_25m;

  vga_timing_gen u_a (
    .clk_25m(clk_25m), .rst_n(rst_n), .ce(ce_a), .hsync(a_hs), .vsync(a_vs), .valid(a_de),
    .pixel_x(a_x), .pixel_y(a_y), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc));

  vga_timing_gen #(.SYNC_DLY(2)) u_b (
    .clk_25m(clk_25m), .rst_n(rst_n), .ce(ce_b), .hsync(b_hs), .vsync(b_vs), .valid(b_de),
    .pixel_x(b_x), .pixel_y(b_y), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc));

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11)
  ) u_c (
    .clk_25m(clk_25m), .rst_n(rst_n), .ce(ce_c), .hsync(c_hs), .vsync(c_vs), .valid(c_de),
    .pixel_x(c_x), .pixel_y(c_y), .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc));

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(4), .FRAME_W(8), .SYNC_DLY(3)
  ) u_d (
    .clk_25m(clk_25m), .rst_n(rst_n), .ce(ce_d), .hsync(d_hs), .vsync(d_vs), .valid(d_de),
    .pixel_x(d_x), .pixel_y(d_y), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc));

  // Expected outputs after k ce edges since reset: raster position is (k-1) mod frame size;
  // sync/valid describe the position SYNC_DLY steps earlier, inactive before step 1.
  function automatic exp_t model(input tparams_t p, input int k);
    exp_t e;
    int ht, vt, fr, pos, x, y, j, x2, y2;
    logic hs_on, vs_on, de_on;
    ht = p.h_act + p.h_fp + p.h_sync + p.h_bp;
    vt = p.v_act + p.v_fp + p.v_sync + p.v_bp;
    fr = ht * vt;
    e = '0;
    if (k == 0) begin
      e.x  = 16'(ht - 1);
      e.y  = 16'(vt - 1);
      e.fc = 16'((1 << p.fw) - 1);
    end else begin
      pos  = (k - 1) % fr;
      x    = pos % ht;
      y    = pos / ht;
      e.x  = 16'(x);
      e.y  = 16'(y);
      e.fc = 16'(((k - 1) / fr) % (1 << p.fw));
      e.ls = (x == 0);
      e.fs = (x == 0) && (y == 0);
    end
    j = k - p.dly;
    hs_on = 1'b0; vs_on = 1'b0; de_on = 1'b0;
    if (j > 0) begin
      x2 = ((j - 1) % fr) % ht;
      y2 = ((j - 1) % fr) / ht;
      hs_on = (x2 >= p.h_act + p.h_fp) && (x2 < p.h_act + p.h_fp + p.h_sync);
      vs_on = (y2 >= p.v_act + p.v_fp) && (y2 < p.v_act + p.v_fp + p.v_sync);
      de_on = (x2 < p.h_act) && (y2 < p.v_act);
    end
    e.hs = hs_on ? p.hs_pol : ~p.hs_pol;
    e.vs = vs_on ? p.vs_pol : ~p.vs_pol;
    e.de = de_on;
    return e;
  endfunction

  function automatic exp_t pack_obs(input logic hs, input logic vs, input logic de,
                                    input logic ls, input logic fs, input logic [15:0] x,
                                    input logic [15:0] y, input logic [15:0] fc);
    exp_t o;
    o.hs = hs; o.vs = vs; o.de = de; o.ls = ls; o.fs = fs; o.x = x; o.y = y; o.fc = fc;
    return o;
  endfunction

  task automatic chk(input string tag, input exp_t obs, input exp_t exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s t=%0d obs x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d exp x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
             tag, tick_n, obs.x, obs.y, obs.hs, obs.vs, obs.de, obs.ls, obs.fs, obs.fc,
             exp.x, exp.y, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dut_a", pack_obs(a_hs, a_vs, a_de, a_ls, a_fs, 16'(a_x), 16'(a_y), 16'(a_fc)), model(P_A, k_a));
    chk("dut_b", pack_obs(b_hs, b_vs, b_de, b_ls, b_fs, 16'(b_x), 16'(b_y), 16'(b_fc)), model(P_B, k_b));
    chk("dut_c", pack_obs(c_hs, c_vs, c_de, c_ls, c_fs, 16'(c_x), 16'(c_y), 16'(c_fc)), model(P_C, k_c));
    chk("dut_d", pack_obs(d_hs, d_vs, d_de, d_ls, d_fs, 16'(d_x), 16'(d_y), 16'(d_fc)), model(P_D, k_d));
  endtask

  task automatic tick();
    @(posedge clk_25m);
    #1;
    tick_n++;
    if (rst_n) begin
      if (ce_a) k_a++;
      if (ce_b) k_b++;
      if (ce_c) k_c++;
      if (ce_d) k_d++;
    end
    check_all();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int hs_low, de_hi, n_a_rise, n_c_rise, n_d_fs;
    int a_rise [2];
    int c_rise [2];
    int d_fs_k [2];
    int b_x656, b_hs_fall, b_x640, b_de_fall;
    logic a_ls_d, c_ls_d, b_hs_d, b_de_d, d_fs_d;
    logic [7:0] d_fc_d;
    int wrap_seen, found;

    // Reset: asserted between edges, outputs must take reset values at once.
    #1 rst_n = 1'b0;
    #1 check_all();
    tick();
    tick();
    #3 rst_n = 1'b1;
    ce_a = 1'b1; ce_b = 1'b1; ce_c = 1'b1; ce_d = 1'b1;

    // Free-running defaults: line period, hsync width, valid width, SYNC_DLY latency.
    hs_low = 0; de_hi = 0; n_a_rise = 0; n_c_rise = 0;
    a_rise = '{-1, -1}; c_rise = '{-1, -1};
    b_x656 = -1; b_hs_fall = -1; b_x640 = -1; b_de_fall = -1;
    a_ls_d = 1'b0; c_ls_d = 1'b0; b_hs_d = b_hs; b_de_d = b_de;
    for (int i = 0; i < 2200; i++) begin
      tick();
      if (i < 1600) begin
        if (a_hs == 1'b0) hs_low++;
        if (a_de == 1'b1) de_hi++;
      end
      if (a_ls && !a_ls_d && n_a_rise < 2) begin a_rise[n_a_rise] = tick_n; n_a_rise++; end
      if (c_ls && !c_ls_d && n_c_rise < 2) begin c_rise[n_c_rise] = tick_n; n_c_rise++; end
      if (b_x == 10'd656 && b_x656 < 0) b_x656 = tick_n;
      if (b_x == 10'd640 && b_x640 < 0) b_x640 = tick_n;
      if (b_hs_d && !b_hs && b_hs_fall < 0) b_hs_fall = tick_n;
      if (b_de_d && !b_de && b_de_fall < 0) b_de_fall = tick_n;
      a_ls_d = a_ls; c_ls_d = c_ls; b_hs_d = b_hs; b_de_d = b_de;
      ce_d = ($urandom_range(0, 7) != 0);
    end
    chk_int("a_hsync_low_2_lines", hs_low, 192);
    chk_int("a_valid_high_2_lines", de_hi, 1280);
    chk_int("a_line_period", a_rise[1] - a_rise[0], 800);
    chk_int("c_line_period", c_rise[1] - c_rise[0], 1056);
    chk_int("b_hsync_fall_lag", b_hs_fall - b_x656, 2);
    chk_int("b_valid_fall_lag", b_de_fall - b_x640, 2);

    // ce toggling 1,0 on dut_a: line period doubles, outputs hold on idle cycles.
    n_a_rise = 0; a_rise = '{-1, -1};
    for (int i = 0; i < 3400; i++) begin
      ce_a = ~ce_a;
      ce_d = ($urandom_range(0, 7) != 0);
      tick();
      if (a_ls && !a_ls_d && n_a_rise < 2) begin a_rise[n_a_rise] = tick_n; n_a_rise++; end
      a_ls_d = a_ls;
    end
    chk_int("a_line_period_half_ce", a_rise[1] - a_rise[0], 1600);

    // Random ce on a/b/d; dut_d runs enough frames to wrap frame_cnt.
    wrap_seen = 0; n_d_fs = 0; d_fs_k = '{-1, -1};
    d_fc_d = d_fc; d_fs_d = d_fs;
    for (int i = 0; i < 24000; i++) begin
      ce_a = ($urandom_range(0, 3) != 0);
      ce_b = ($urandom_range(0, 3) != 0);
      ce_c = 1'b1;
      ce_d = ($urandom_range(0, 7) != 0);
      tick();
      if (d_fc_d == 8'd255 && d_fc == 8'd0) wrap_seen++;
      if (d_fs && !d_fs_d && n_d_fs < 2) begin d_fs_k[n_d_fs] = k_d; n_d_fs++; end
      d_fc_d = d_fc; d_fs_d = d_fs;
    end
    chk_int("d_frame_cnt_wrap_seen", (wrap_seen > 0) ? 1 : 0, 1);
    chk_int("d_frame_period_ce_steps", d_fs_k[1] - d_fs_k[0], 70);

    // Asynchronous reset mid-line at pixel_x=300 on dut_a.
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      ce_a = ($urandom_range(0, 3) != 0);
      ce_d = ($urandom_range(0, 7) != 0);
      tick();
      if (a_x == 10'd300) found = 1;
    end
    chk_int("a_reached_x300", found, 1);
    #3 rst_n = 1'b0;
    k_a = 0; k_b = 0; k_c = 0; k_d = 0;
    #1 check_all();
    tick();
    #3 rst_n = 1'b1;
    ce_a = 1'b1; ce_b = 1'b1; ce_c = 1'b1; ce_d = 1'b1;
    tick();
    chk_int("a_first_x_after_reset", int'(a_x), 0);
    chk_int("a_first_y_after_reset", int'(a_y), 0);
    chk_int("a_first_fs_after_reset", int'(a_fs), 1);
    chk_int("a_first_fc_after_reset", int'(a_fc), 0);

    for (int i = 0; i < 300; i++) begin
      ce_a = ($urandom_range(0, 1) != 0);
      ce_b = ($urandom_range(0, 1) != 0);
      ce_c = ($urandom_range(0, 1) != 0);
      ce_d = ($urandom_range(0, 1) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
